// File: rtl/seq_detector_param.sv
// seq_detector_param: detects a programmable PAT_LEN-bit serial pattern and counts matches.
// Moore state is the fill count of valid history bits; match is a registered pulse.
module seq_detector_param #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W = 8,
    parameter logic [PAT_LEN-1:0] RESET_PATTERN = 4'b1011,
    parameter logic RESET_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cfg_load,
    input  logic [PAT_LEN-1:0]             cfg_pattern,
    input  logic                           cfg_overlap,
    input  logic                           in_valid,
    input  logic                           in_bit,
    input  logic                           clr_count,
    output logic                           match,
    output logic [CNT_W-1:0]               match_count,
    output logic [$clog2(PAT_LEN+1)-1:0]   fill_level
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
    localparam logic [FW-1:0] LAST = FW'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] pattern_q, hist, cand, hist_d;
    logic               overlap_q, accept, hit;
    logic [FW-1:0]      fill, fill_d;
    logic [CNT_W-1:0]   count_d;

    always_comb begin
        accept  = in_valid && !cfg_load;
        cand    = {hist[PAT_LEN-2:0], in_bit};
        hit     = accept && (fill >= LAST) && (cand == pattern_q);
        hist_d  = cfg_load ? '0 : accept ? cand : hist;
        // a non-overlap hit consumes its bits, so fill restarts from zero
        fill_d  = (cfg_load || (hit && !overlap_q)) ? '0 :
                  !accept ? fill : (fill == FULL) ? FULL : fill + 1'b1;
        count_d = clr_count ? '0 : (hit && match_count != '1) ? match_count + 1'b1 : match_count;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pattern_q   <= RESET_PATTERN;
            overlap_q   <= RESET_OVERLAP;
            hist        <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                overlap_q <= cfg_overlap;
            end
            hist        <= hist_d;
            fill        <= fill_d;
            match       <= hit;
            match_count <= count_d;
        end
    end

    assign fill_level = fill;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: random and directed checks of two detector instances
// (4-bit/8-bit counter default, and 2-bit pattern 11 with a 2-bit counter) against a queue model.
module tb_seq_detector_param;
    logic clk = 0, rn = 0;
    logic ld = 0, ov = 0, v = 0, b = 0, clr = 0;
    logic [3:0] pat = 0;
    logic m_a;
    logic [7:0] cnt_a;
    logic [2:0] fl_a;
    logic ld2 = 0, ov2 = 0, v2 = 0, b2 = 0, clr2 = 0;
    logic [1:0] pat2 = 0;
    logic m_b;
    logic [1:0] cnt_b;
    logic [1:0] fl_b;

    int total = 0, bad = 0;
    int ptn[2], ec[2], ef[2];
    bit ovm[2], em[2];
    bit qa[$], qb[$];

    always #5 clk = ~clk;

    seq_detector_param dut_a (
        .clk(clk), .reset_n(rn), .cfg_load(ld), .cfg_pattern(pat), .cfg_overlap(ov),
        .in_valid(v), .in_bit(b), .clr_count(clr),
        .match(m_a), .match_count(cnt_a), .fill_level(fl_a)
    );

    seq_detector_param #(.PAT_LEN(2), .CNT_W(2), .RESET_PATTERN(2'b11), .RESET_OVERLAP(1'b1)) dut_b (
        .clk(clk), .reset_n(rn), .cfg_load(ld2), .cfg_pattern(pat2), .cfg_overlap(ov2),
        .in_valid(v2), .in_bit(b2), .clr_count(clr2),
        .match(m_b), .match_count(cnt_b), .fill_level(fl_b)
    );

    function automatic int tail(input bit q[$], input int len);
        int r = 0;
        for (int i = q.size() - len; i < q.size(); i++) r = r * 2 + int'(q[i]);
        return r;
    endfunction

    // Model: keep the bits accepted since the last restart; a match is the last
    // PAT_LEN of them equalling the pattern once at least PAT_LEN are present.
    task automatic mstep(input int k, input bit rn_i, ld_i, input int pat_i, input bit ov_i, v_i, b_i, clr_i);
        int len = k ? 2 : 4;
        int cmax = k ? 3 : 255;
        bit hit = 0;
        int sz;
        if (!rn_i) begin
            ptn[k] = k ? 3 : 11;
            ovm[k] = 1;
            if (k == 0) qa.delete(); else qb.delete();
            em[k] = 0;
            ec[k] = 0;
        end else begin
            if (ld_i) begin
                ptn[k] = pat_i;
                ovm[k] = ov_i;
                if (k == 0) qa.delete(); else qb.delete();
            end else if (v_i) begin
                if (k == 0) qa.push_back(b_i); else qb.push_back(b_i);
                sz = k ? qb.size() : qa.size();
                hit = sz >= len && tail(k ? qb : qa, len) == ptn[k];
                if (hit && !ovm[k]) begin
                    if (k == 0) qa.delete(); else qb.delete();
                end else if (sz > len) begin
                    if (k == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                end
            end
            em[k] = hit;
            ec[k] = clr_i ? 0 : (hit && ec[k] < cmax) ? ec[k] + 1 : ec[k];
        end
        ef[k] = k ? qb.size() : qa.size();
    endtask

    task automatic cyc();
        mstep(0, rn, ld, int'(pat), ov, v, b, clr);
        mstep(1, rn, ld2, int'(pat2), ov2, v2, b2, clr2);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rn = 0;
        cyc();
        rn = 1;
        total++;
        if (m_a !== 0 || cnt_a !== 0 || fl_a !== 0 || m_b !== 0 || cnt_b !== 0 || fl_b !== 0) begin
            bad++;
            $display("FAIL reset: a m=%0b cnt=%0d fill=%0d b m=%0b cnt=%0d fill=%0d required all 0",
                     m_a, cnt_a, fl_a, m_b, cnt_b, fl_b);
        end
    endtask

    task automatic test_stream(input string name, input logic [6:0] bits, input logic [6:0] want_mask,
                               input int want_cnt, input int want_fill);
        logic [6:0] mask = 0;
        for (int i = 0; i < 7; i++) begin
            v = 1;
            b = bits[6 - i];
            cyc();
            mask[i] = m_a;
            total++;
            if (m_a !== em[0] || cnt_a !== 8'(ec[0]) || fl_a !== 3'(ef[0])) begin
                bad++;
                $display("FAIL %s bit%0d: m=%0b cnt=%0d fill=%0d required m=%0b cnt=%0d fill=%0d",
                         name, i, m_a, cnt_a, fl_a, em[0], ec[0], ef[0]);
            end
        end
        v = 0;
        total++;
        if (mask !== want_mask || cnt_a !== 8'(want_cnt) || fl_a !== 3'(want_fill)) begin
            bad++;
            $display("FAIL %s summary: pulses=%b cnt=%0d fill=%0d required pulses=%b cnt=%0d fill=%0d",
                     name, mask, cnt_a, fl_a, want_mask, want_cnt, want_fill);
        end
    endtask

    task automatic test_overlap();
        test_stream("overlap", 7'b1011011, 7'b1001000, 2, 4);
    endtask

    task automatic test_non_overlap();
        ld = 1; pat = 4'b1011; ov = 0;
        cyc();
        ld = 0;
        test_stream("non_overlap", 7'b1011011, 7'b0001000, 3, 3);
    endtask

    task automatic test_bubbles();
        logic [3:0] bits = 4'b1011;
        int pulses = 0;
        ld = 1; pat = 4'b1011; ov = 1;
        cyc();
        ld = 0;
        for (int i = 0; i < 4; i++) begin
            v = 1;
            b = bits[3 - i];
            cyc();
            pulses += int'(m_a);
            total++;
            if (m_a !== em[0] || m_a !== (i == 3) || fl_a !== 3'(ef[0])) begin
                bad++;
                $display("FAIL bubbles bit%0d: m=%0b fill=%0d required m=%0b fill=%0d", i, m_a, fl_a, em[0], ef[0]);
            end
            v = 0;
            for (int j = 0; j < 3; j++) begin
                cyc();
                total++;
                if (m_a !== 0 || fl_a !== 3'(ef[0]) || cnt_a !== 8'(ec[0])) begin
                    bad++;
                    $display("FAIL bubbles idle%0d.%0d: m=%0b fill=%0d cnt=%0d required m=0 fill=%0d cnt=%0d",
                             i, j, m_a, fl_a, cnt_a, ef[0], ec[0]);
                end
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL bubbles pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_midload();
        v = 1; b = 1;
        cyc();
        ld = 1; pat = 4'b0110; ov = 1; v = 1; b = 1;
        cyc();
        ld = 0;
        total++;
        if (fl_a !== 0 || m_a !== 0) begin
            bad++;
            $display("FAIL midload load: fill=%0d m=%0b required fill=0 m=0", fl_a, m_a);
        end
        test_stream("midload", 7'b0110110, 7'b1001000, 6, 4);
    endtask

    task automatic test_saturate();
        int run = 0, best = 0;
        ld2 = 1; pat2 = 2'b11; ov2 = 1;
        cyc();
        ld2 = 0;
        for (int i = 0; i < 8; i++) begin
            v2 = 1; b2 = 1;
            cyc();
            run = m_b ? run + 1 : 0;
            if (run > best) best = run;
            total++;
            if (m_b !== em[1] || cnt_b !== 2'(ec[1]) || fl_b !== 2'(ef[1])) begin
                bad++;
                $display("FAIL saturate bit%0d: m=%0b cnt=%0d fill=%0d required m=%0b cnt=%0d fill=%0d",
                         i, m_b, cnt_b, fl_b, em[1], ec[1], ef[1]);
            end
        end
        total++;
        if (best != 7 || cnt_b !== 2'd3) begin
            bad++;
            $display("FAIL saturate run: run=%0d cnt=%0d required run=7 cnt=3", best, cnt_b);
        end
        clr2 = 1;
        cyc();
        clr2 = 0; v2 = 0;
        total++;
        if (cnt_b !== 0 || m_b !== 1) begin
            bad++;
            $display("FAIL clr_with_hit: cnt=%0d m=%0b required cnt=0 m=1", cnt_b, m_b);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] bits = 4'b1011;
        v = 1; b = 1; cyc();
        b = 0; cyc();
        rn = 0; b = 1; cyc();
        rn = 1; v = 0;
        total++;
        if (cnt_a !== 0 || fl_a !== 0 || m_a !== 0) begin
            bad++;
            $display("FAIL mid_reset: cnt=%0d fill=%0d m=%0b required 0 0 0", cnt_a, fl_a, m_a);
        end
        for (int i = 0; i < 4; i++) begin
            v = 1; b = bits[3 - i];
            cyc();
            total++;
            if (m_a !== (i == 3) || cnt_a !== 8'(i == 3) || m_a !== em[0]) begin
                bad++;
                $display("FAIL after_reset bit%0d: m=%0b cnt=%0d required m=%0b cnt=%0d",
                         i, m_a, cnt_a, i == 3, i == 3);
            end
        end
        v = 0;
        cyc();
        total++;
        if (m_a !== 0) begin
            bad++;
            $display("FAIL after_reset pulse width: m=%0b required 0", m_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rn = $urandom_range(0, 150) != 0;
            ld = $urandom_range(0, 40) == 0; pat = 4'($urandom); ov = 1'($urandom);
            v = $urandom_range(0, 3) != 0; b = 1'($urandom); clr = $urandom_range(0, 60) == 0;
            ld2 = $urandom_range(0, 40) == 0; pat2 = 2'($urandom); ov2 = 1'($urandom);
            v2 = $urandom_range(0, 3) != 0; b2 = 1'($urandom); clr2 = $urandom_range(0, 30) == 0;
            cyc();
            total++;
            if (m_a !== em[0] || cnt_a !== 8'(ec[0]) || fl_a !== 3'(ef[0]) ||
                m_b !== em[1] || cnt_b !== 2'(ec[1]) || fl_b !== 2'(ef[1])) begin
                bad++;
                $display("FAIL random cyc%0d: a %0b/%0d/%0d b %0b/%0d/%0d required a %0b/%0d/%0d b %0b/%0d/%0d",
                         i, m_a, cnt_a, fl_a, m_b, cnt_b, fl_b, em[0], ec[0], ef[0], em[1], ec[1], ef[1]);
            end
        end
        rn = 1; ld = 0; v = 0; clr = 0; ld2 = 0; v2 = 0; clr2 = 0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_bubbles();
        test_midload();
        test_saturate();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector. It generalises the fixed 4-bit Moore sequence detector to a runtime-programmable pattern of PAT_LEN bits. It adds an overlap/non-overlap mode, an input-valid qualifier, and a saturating match counter. It sits on a serial bit stream and flags each complete occurrence of the programmed pattern with a registered, Moore-style one-cycle pulse.

Parameters:
PAT_LEN, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the match counter.
RESET_PATTERN, 4'b1011, pattern loaded at reset, PAT_LEN bits wide, MSB = first bit received.
RESET_OVERLAP, 1, overlap mode selected at reset.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset_n  input  1  reset, synchronous, active-low.
cfg_load  input  1  when 1, latch cfg_pattern/cfg_overlap and restart detection.
cfg_pattern  input  PAT_LEN  new pattern, MSB = first bit of the sequence.
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = matched bits are consumed.
in_valid  input  1  qualifies in_bit; bits are accepted only when 1.
in_bit  input  1  serial data bit.
clr_count  input  1  synchronous clear of match_count.
match  output  1  registered pulse, high for exactly one cycle after a pattern completes.
match_count  output  CNT_W  number of matches since reset/clear, saturating.
fill_level  output  $clog2(PAT_LEN+1)  number of valid history bits currently held (0..PAT_LEN).

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - pattern_q <= RESET_PATTERN; overlap_q <= RESET_OVERLAP.
  - hist <= 0; fill_level <= 0; match <= 0; match_count <= 0.
  - Reset overrides every other input.
- Internal state:
  - hist: PAT_LEN-bit shift register.
  - fill: saturating count 0..PAT_LEN, the Moore state. State k means the last k accepted bits are valid history.
  - pattern_q and overlap_q: configuration registers.
- Accepted bit (in_valid=1, cfg_load=0):
  - cand = {hist[PAT_LEN-2:0], in_bit}.
  - hit = (fill+1 >= PAT_LEN) && (cand == pattern_q).
  - hist <= cand.
- fill update on an accepted bit:
  - hit && overlap_q=0: fill <= 0, so matched bits cannot contribute to the next match.
  - otherwise: fill <= min(fill+1, PAT_LEN).
- in_valid=0: hist, fill and the counter hold.
- match:
  - match <= hit every cycle, so it is 0 on any cycle with no accepted hit.
  - Latency: match is high in the cycle after the edge that accepts the completing bit.
  - Never high for two consecutive cycles unless hits are accepted on consecutive cycles (e.g. pattern 11 in overlap mode with a continuous stream of 1s).
- match_count:
  - On hit, increments by 1, saturating at 2^CNT_W-1.
  - clr_count=1 forces it to 0 and takes priority over a simultaneous hit.
  - The count is unaffected by cfg_load.
- cfg_load=1 (reset_n=1):
  - pattern_q <= cfg_pattern; overlap_q <= cfg_overlap.
  - hist <= 0; fill <= 0; match <= 0.
  - Any in_bit presented in the same cycle is discarded (load wins).
- Mid-stream config change: partial progress is lost; detection restarts from fill=0 with the new pattern.
- No hit is possible until PAT_LEN bits have been accepted since reset, load, or a non-overlap match, even if hist bits happen to equal the pattern.
- fill_level reflects fill directly.

Test Plan:
1. Reset defaults (1011, overlap). Stream 1,0,1,1,0,1,1 with in_valid=1 -> match pulses one cycle after bit 4 and after bit 7; match_count=2; fill_level=4 at end.
2. cfg_load pattern 1011 with overlap=0. Same stream 1,0,1,1,0,1,1 -> single match after bit 4; fill_level=3 at end; match_count increments by 1.
3. Stream 1,0,1,1 with in_valid dropped for 3 cycles between each bit -> one match after the 4th accepted bit; match stays 0 during bubbles.
4. After the first bit of a 1011 stream, assert cfg_load (pattern 0110, overlap=1) with in_valid=1 in that cycle. Then stream 0,1,1,0,1,1,0 -> loaded-cycle bit is discarded; matches after bits 4 and 7; no 1011 match.
5. CNT_W=2, overlap, pattern 11 (PAT_LEN=2), eight consecutive 1s -> match high 7 consecutive cycles; match_count saturates at 3. Then clr_count asserted together with a hit -> match_count=0, match still pulses.
6. Assert reset_n=0 for one cycle in the middle of 1,0,1 -> match_count=0, fill_level=0. Then 1,0,1,1 -> match exactly one cycle after the 4th bit with the default pattern.
